// File: rtl/sd_cmd_arb_pkg.sv
// Shared types and constants for the SD command arbiter.
// Holds the FSM state encoding, the completion status codes and the default issue timeout.
package sd_cmd_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  localparam logic [1:0] OK       = 2'b00;
  localparam logic [1:0] CMD_ERR  = 2'b01;
  localparam logic [1:0] ISSUE_TO = 2'b10;
  localparam logic [1:0] NO_CARD  = 2'b11;

  localparam int ISSUE_TIMEOUT_DEF = 255;

endpackage

// File: rtl/sd_cmd_arbiter_if.sv
// Command-master side of the arbiter: New_CMD/ARG/CMD_SET outward, status and response inward.
// The master modport belongs to the arbiter, the slave modport to the command master.
interface sd_cmd_arbiter_if;
  logic        new_cmd_o;
  logic [31:0] arg_o;
  logic [13:0] cmd_set_o;
  logic        data_read_o;
  logic        data_write_o;
  logic        cmd_busy_i;
  logic        cc_i;
  logic        ei_i;
  logic [4:0]  err_int_i;
  logic [31:0] resp_i;
  logic        card_present_i;

  modport master (
    output new_cmd_o, arg_o, cmd_set_o, data_read_o, data_write_o,
    input  cmd_busy_i, cc_i, ei_i, err_int_i, resp_i, card_present_i
  );

  modport slave (
    input  new_cmd_o, arg_o, cmd_set_o, data_read_o, data_write_o,
    output cmd_busy_i, cc_i, ei_i, err_int_i, resp_i, card_present_i
  );
endinterface

// File: rtl/sd_rr_arb2.sv
// Two-way round-robin picker: a lone requester always wins, a tie goes to
// the requester that was not granted last.
module sd_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = last ? 2'b01 : 2'b10;
    end
  end
endmodule

// File: rtl/sd_cmd_arbiter.sv
// Arbitrates the host register path and the data-path auto-command onto one
// SD command master: grant, New_CMD handshake with timeout, one-cycle done pulse.
module sd_cmd_arbiter
  import sd_cmd_arb_pkg::*;
#(
  parameter int ISSUE_TIMEOUT = ISSUE_TIMEOUT_DEF
) (
  input  logic             CLK_PAD_IO,
  input  logic             RST_PAD_I_N,
  input  logic [1:0]       req_i,
  input  logic [31:0]      arg0_i,
  input  logic [31:0]      arg1_i,
  input  logic [13:0]      set0_i,
  input  logic [13:0]      set1_i,
  input  logic [1:0]       dir0_i,
  input  logic [1:0]       dir1_i,
  output logic [1:0]       gnt_o,
  output logic [1:0]       done_o,
  output logic [1:0]       stat_o,
  output logic [4:0]       err_code_o,
  output logic [31:0]      resp_o,
  sd_cmd_arbiter_if.master cm
);

  arb_state_e state_q, state_d;
  logic       last_q;
  logic [1:0] pick;
  logic [7:0] issue_cnt_q;
  logic       issue_expired;
  logic       grant_en;
  logic       stat_en;
  logic       capture_en;
  logic [1:0] stat_d;

  sd_rr_arb2 u_rr (
    .req  (req_i),
    .last (last_q),
    .gnt  (pick)
  );

  // The count includes the current ISSUE cycle, so ISSUE lasts exactly ISSUE_TIMEOUT cycles.
  assign issue_expired = ({24'd0, issue_cnt_q} + 32'd1) >= 32'(ISSUE_TIMEOUT);

  assign cm.new_cmd_o = (state_q == ISSUE);
  assign done_o       = (state_q == DONE) ? gnt_o : 2'b00;

  always_comb begin
    state_d    = state_q;
    grant_en   = 1'b0;
    stat_en    = 1'b0;
    capture_en = 1'b0;
    stat_d     = stat_o;
    unique case (state_q)
      IDLE: begin
        if (|req_i) begin
          grant_en = 1'b1;
          if (!cm.card_present_i) begin
            state_d = DONE;
            stat_en = 1'b1;
            stat_d  = NO_CARD;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (cm.cmd_busy_i) begin
          state_d = WAIT;
        end else if (issue_expired) begin
          state_d = DONE;
          stat_en = 1'b1;
          stat_d  = ISSUE_TO;
        end
      end
      WAIT: begin
        if (!cm.cmd_busy_i) begin
          state_d    = DONE;
          stat_en    = 1'b1;
          capture_en = 1'b1;
          stat_d     = (cm.ei_i || !cm.cc_i) ? CMD_ERR : OK;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_PAD_IO or negedge RST_PAD_I_N) begin
    if (!RST_PAD_I_N) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK_PAD_IO or negedge RST_PAD_I_N) begin
    if (!RST_PAD_I_N) begin
      last_q          <= 1'b1;
      gnt_o           <= 2'b00;
      issue_cnt_q     <= 8'd0;
      cm.arg_o        <= 32'd0;
      cm.cmd_set_o    <= 14'd0;
      cm.data_read_o  <= 1'b0;
      cm.data_write_o <= 1'b0;
      stat_o          <= OK;
      err_code_o      <= 5'd0;
      resp_o          <= 32'd0;
    end else begin
      // Command fields are frozen at grant so requester-side changes cannot disturb the master.
      if (grant_en) begin
        gnt_o           <= pick;
        last_q          <= pick[1];
        issue_cnt_q     <= 8'd0;
        cm.arg_o        <= pick[1] ? arg1_i : arg0_i;
        cm.cmd_set_o    <= pick[1] ? set1_i : set0_i;
        cm.data_read_o  <= pick[1] ? dir1_i[1] : dir0_i[1];
        cm.data_write_o <= pick[1] ? dir1_i[0] : dir0_i[0];
      end else if (state_q == DONE) begin
        gnt_o <= 2'b00;
      end
      if (state_q == ISSUE && issue_cnt_q != 8'hFF) begin
        issue_cnt_q <= issue_cnt_q + 8'd1;
      end
      if (stat_en) begin
        stat_o <= stat_d;
      end
      if (capture_en) begin
        resp_o     <= cm.resp_i;
        err_code_o <= cm.err_int_i;
      end
    end
  end

endmodule

// File: tb/tb_sd_cmd_arbiter.sv
// Randomized bench for sd_cmd_arbiter: a transaction-timeline model predicts every
// output each cycle, plus directed scenarios with literal expectations.
module tb_sd_cmd_arbiter;
  import sd_cmd_arb_pkg::*;

  localparam int T = 255;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req;
  logic [31:0] a0, a1;
  logic [13:0] s0, s1;
  logic [1:0]  d0, d1;
  logic [1:0]  gnt, done, stat;
  logic [4:0]  err;
  logic [31:0] resp;

  always #5 clk = ~clk;

  sd_cmd_arbiter_if cm ();

  sd_cmd_arbiter #(.ISSUE_TIMEOUT(T)) dut (
    .CLK_PAD_IO  (clk),
    .RST_PAD_I_N (rst_n),
    .req_i       (req),
    .arg0_i      (a0),
    .arg1_i      (a1),
    .set0_i      (s0),
    .set1_i      (s1),
    .dir0_i      (d0),
    .dir1_i      (d1),
    .gnt_o       (gnt),
    .done_o      (done),
    .stat_o      (stat),
    .err_code_o  (err),
    .resp_o      (resp),
    .cm          (cm)
  );

  // expected outputs for the current cycle
  logic [1:0]  e_gnt = 0, e_done = 0, e_stat = 0;
  logic [4:0]  e_err = 0;
  logic [31:0] e_resp = 0, e_arg = 0;
  logic [13:0] e_set = 0;
  logic        e_new = 0, e_rd = 0, e_wr = 0;
  int          m_last = 1;

  int n_pass = 0, n_chk = 0;
  int cyc = 0, t_req = 0, t_done = 0, done_cnt = 0;
  int nc_run = 0, nc_last = 0, nc_total = 0;
  logic [1:0]  gnt_prev = 0;
  logic [1:0]  gq[$];
  logic [1:0]  cap_done = 0, cap_stat = 0;
  logic [31:0] cap_resp = 0;
  logic [4:0]  cap_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    chk("gnt_o", 32'(gnt), 32'(e_gnt));
    chk("done_o", 32'(done), 32'(e_done));
    chk("new_cmd_o", 32'(cm.new_cmd_o), 32'(e_new));
    chk("stat_o", 32'(stat), 32'(e_stat));
    chk("err_code_o", 32'(err), 32'(e_err));
    chk("resp_o", resp, e_resp);
    if (e_gnt != 2'b00) begin
      chk("arg_o", cm.arg_o, e_arg);
      chk("cmd_set_o", 32'(cm.cmd_set_o), 32'(e_set));
      chk("data_read_o", 32'(cm.data_read_o), 32'(e_rd));
      chk("data_write_o", 32'(cm.data_write_o), 32'(e_wr));
    end
    if (cm.new_cmd_o) begin
      nc_run++;
      nc_total++;
    end else begin
      if (nc_run != 0) nc_last = nc_run;
      nc_run = 0;
    end
    if (gnt != 2'b00 && gnt_prev == 2'b00) gq.push_back(gnt);
    gnt_prev = gnt;
    if (done != 2'b00) begin
      cap_done = done; cap_stat = stat; cap_resp = resp; cap_err = err;
      t_done = cyc;
      done_cnt++;
    end
    cyc++;
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    a0 = $urandom; a1 = $urandom;
    s0 = 14'($urandom); s1 = 14'($urandom);
    d0 = 2'($urandom); d1 = 2'($urandom);
  endtask

  task automatic junk_cm();
    cm.resp_i = $urandom; cm.err_int_i = 5'($urandom);
    cm.cc_i = 1'($urandom); cm.ei_i = 1'($urandom);
  endtask

  // One transaction from an IDLE cycle: r = ISSUE cycles before busy, h = extra busy cycles in WAIT.
  task automatic do_txn(input logic [1:0] r_req, input bit card, input int r, input int h,
                        input bit tmo, input bit cc, input bit ei, input logic [31:0] rv,
                        input logic [4:0] ev, input bit chaos);
    int w, n_issue;
    logic [31:0] g_arg;
    logic [13:0] g_set;
    logic [1:0]  g_dir;
    req = r_req; cm.card_present_i = card; cm.cmd_busy_i = 1'b0;
    scramble(); junk_cm();
    t_req = cyc;
    w = (r_req == 2'b11) ? 1 - m_last : (r_req[1] ? 1 : 0);
    m_last = w;
    g_arg = w ? a1 : a0; g_set = w ? s1 : s0; g_dir = w ? d1 : d0;
    step();
    e_gnt = 2'(1 << w); e_arg = g_arg; e_set = g_set; e_rd = g_dir[1]; e_wr = g_dir[0];
    if (chaos) begin req = 2'($urandom); scramble(); end
    if (!card) begin
      e_done = e_gnt; e_stat = NO_CARD; e_new = 1'b0;
    end else begin
      n_issue = tmo ? T : r + 1;
      for (int k = 0; k < n_issue; k++) begin
        e_new = 1'b1;
        cm.cmd_busy_i = !tmo && (k == r);
        cm.card_present_i = 1'($urandom);
        junk_cm();
        if (chaos) begin req = 2'($urandom); scramble(); end
        step();
      end
      e_new = 1'b0;
      if (!tmo) begin
        for (int j = 0; j <= h; j++) begin
          cm.cmd_busy_i = (j < h);
          if (j == h) begin
            cm.resp_i = rv; cm.err_int_i = ev; cm.cc_i = cc; cm.ei_i = ei;
          end else begin
            junk_cm();
          end
          if (chaos) begin req = 2'($urandom); scramble(); end
          step();
        end
        e_resp = rv; e_err = ev;
        e_stat = (ei || !cc) ? CMD_ERR : OK;
      end else begin
        e_stat = ISSUE_TO;
      end
      e_done = e_gnt;
      cm.cmd_busy_i = 1'b0;
      junk_cm();
    end
    step();
    e_gnt = 2'b00; e_done = 2'b00;
    req = 2'b00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      req = 2'b00; scramble(); junk_cm();
      step();
    end
  endtask

  task automatic reset_in_wait();
    int dc;
    req = 2'b10; cm.card_present_i = 1'b1; cm.cmd_busy_i = 1'b0; scramble();
    m_last = 1;
    e_arg = a1; e_set = s1; e_rd = d1[1]; e_wr = d1[0];
    step();
    e_gnt = 2'b10; e_new = 1'b1; cm.cmd_busy_i = 1'b1;
    step();
    e_new = 1'b0;
    step();
    step();
    dc = done_cnt;
    rst_n = 1'b0;
    e_gnt = 0; e_done = 0; e_stat = 0; e_err = 0; e_resp = 0; e_new = 0;
    #1;
    chk("rst_wait gnt_o", 32'(gnt), 32'd0);
    chk("rst_wait new_cmd_o", 32'(cm.new_cmd_o), 32'd0);
    chk("rst_wait arg_o", cm.arg_o, 32'd0);
    chk("rst_wait cmd_set_o", 32'(cm.cmd_set_o), 32'd0);
    chk("rst_wait dir", 32'({cm.data_read_o, cm.data_write_o}), 32'd0);
    step();
    cm.cmd_busy_i = 1'b0;
    step();
    rst_n = 1'b1;
    m_last = 1;
    req = 2'b00;
    step();
    chk("rst_wait no done", 32'(done_cnt), 32'(dc));
  endtask

  initial begin
    req = 0; scramble();
    cm.cmd_busy_i = 0; cm.card_present_i = 1; cm.cc_i = 0; cm.ei_i = 0;
    cm.err_int_i = 0; cm.resp_i = 0;
    #2;
    chk("reset gnt_o", 32'(gnt), 32'd0);
    chk("reset new_cmd_o", 32'(cm.new_cmd_o), 32'd0);
    chk("reset resp_o", resp, 32'd0);
    chk("reset arg_o", cm.arg_o, 32'd0);
    #10;
    rst_n = 1'b1;
    step();

    // both requesters held: strict alternation starting with requester 0
    gq.delete();
    for (int i = 0; i < 4; i++)
      do_txn(2'b11, 1, $urandom_range(0, 3), $urandom_range(0, 3), 0, 1, 0, $urandom, 5'd0, 0);
    chk("alt count", 32'(gq.size()), 32'd4);
    if (gq.size() == 4) begin
      chk("alt g0", 32'(gq[0]), 32'h1);
      chk("alt g1", 32'(gq[1]), 32'h2);
      chk("alt g2", 32'(gq[2]), 32'h1);
      chk("alt g3", 32'(gq[3]), 32'h2);
    end

    // requester 0, busy one cycle after New_CMD and held for ten cycles
    idle(2);
    cap_done = 0;
    do_txn(2'b01, 1, 1, 9, 0, 1, 0, 32'hDEADBEEF, 5'd0, 0);
    chk("basic done", 32'(cap_done), 32'h1);
    chk("basic stat", 32'(cap_stat), 32'h0);
    chk("basic resp", cap_resp, 32'hDEADBEEF);

    // minimum latency path
    do_txn(2'b01, 1, 0, 0, 0, 1, 0, $urandom, 5'd0, 0);
    chk("min latency", 32'(t_done - t_req + 1), 32'd4);

    // no card present
    idle(1);
    nc_total = 0; cap_done = 0;
    do_txn(2'b10, 0, 0, 0, 0, 1, 0, 32'd0, 5'd0, 0);
    chk("nocard done", 32'(cap_done), 32'h2);
    chk("nocard stat", 32'(cap_stat), 32'h3);
    chk("nocard latency", 32'(t_done - t_req + 1), 32'd2);
    chk("nocard new_cmd", 32'(nc_total), 32'd0);

    // completion with error interrupt
    do_txn(2'b01, 1, 2, 3, 0, 1, 1, $urandom, 5'b00001, 0);
    chk("err stat", 32'(cap_stat), 32'h1);
    chk("err code", 32'(cap_err), 32'h1);

    // busy stuck low
    do_txn(2'b10, 1, 0, 0, 1, 1, 0, 32'd0, 5'd0, 0);
    chk("timeout new_cmd cycles", 32'(nc_last), 32'd255);
    chk("timeout stat", 32'(cap_stat), 32'h2);

    // randomized traffic with mid-transaction input churn
    for (int i = 0; i < 60; i++) begin
      logic [1:0] rq;
      rq = 2'($urandom_range(1, 3));
      do_txn(rq, ($urandom_range(0, 7) != 0), $urandom_range(0, 6), $urandom_range(0, 8),
             ($urandom_range(0, 29) == 0), 1'($urandom), 1'($urandom), $urandom,
             5'($urandom), 1);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end

    // reset in WAIT abandons the transaction and restores requester-0 priority
    reset_in_wait();
    do_txn(2'b11, 1, 0, 1, 0, 1, 0, $urandom, 5'd0, 0);
    chk("post-reset grant", 32'(gq[gq.size()-1]), 32'h1);

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
